// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI mode-0 slave. It oversamples sclk/cs/mosi in the clk domain,
// deserialises MSB-first DATA_WIDTH-bit frames onto a valid/ready RX port, and
// shifts a preloaded TX word out on miso.
// Optional: define SPI_SLAVE_FRAME_ERR_EN to add the frame_err pulse output
// (mid-frame cs abort, or extra sclk edges after the last bit).
module spi_slave_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_overrun,
  output logic                  busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
  ,
  output logic                  frame_err
`endif
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, WAIT_CS} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_d, cs_d;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [DATA_WIDTH-1:0]  tx_buf, tx_shift, rx_shift;
  logic                   tx_full;
  logic [CW-1:0]          bit_cnt;
  logic                   done_q;

  // strobes decoded by the FSM
  logic start, sample, shift_out, last_bit, abort, go_idle;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic extra_clk;
`endif

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  assign tx_ready  = ~tx_full;
  assign busy      = (state != IDLE);

  // Input synchronisers plus one delayed copy for edge detection; cs idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and per-cycle strobes; cs rising beats a same-cycle sclk sample.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    sample    = 1'b0;
    shift_out = 1'b0;
    last_bit  = 1'b0;
    abort     = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    extra_clk = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (cs_fall) begin
          start     = 1'b1;
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          if (sclk_rise) begin
            sample = 1'b1;
            if (bit_cnt == LAST_BIT) begin
              last_bit  = 1'b1;
              state_nxt = WAIT_CS;
            end
          end
          // bit_cnt stays below DATA_WIDTH while ACTIVE, so only the lower bound matters
          if (sclk_fall && bit_cnt != '0) shift_out = 1'b1;
        end
      end
      WAIT_CS: begin
`ifdef SPI_SLAVE_FRAME_ERR_EN
        extra_clk = sclk_rise;
`endif
        if (cs_rise) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign go_idle = (state != IDLE) && (state_nxt == IDLE);

  // TX buffer, shift registers, bit counter and miso.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_buf   <= '0;
      tx_full  <= 1'b0;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
      miso     <= 1'b0;
    end else begin
      // a new word accepted on the frame-start cycle keeps the buffer full
      if (tx_valid && !tx_full) begin
        tx_buf  <= tx_data;
        tx_full <= 1'b1;
      end else if (start) begin
        tx_full <= 1'b0;
      end
      if (start) begin
        tx_shift <= tx_full ? tx_buf : '0;
        miso     <= tx_full & tx_buf[DATA_WIDTH-1];
        rx_shift <= '0;
        bit_cnt  <= '0;
      end
      if (shift_out) begin
        tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
        miso     <= tx_shift[DATA_WIDTH-2];
      end
      if (sample) begin
        rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
        bit_cnt  <= bit_cnt + CW'(1);
      end
      if (abort)   rx_shift <= '0;
      if (go_idle) miso     <= 1'b0;
    end
  end

  // RX output register: frame posted the cycle after the last sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q     <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      done_q     <= last_bit;
      rx_overrun <= 1'b0;
      if (done_q) begin
        rx_data    <= rx_shift;
        rx_valid   <= 1'b1;
        rx_overrun <= rx_valid & ~rx_ready;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef SPI_SLAVE_FRAME_ERR_EN
  // Error pulse on aborted frames or sclk activity after the last bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_err <= 1'b0;
    else       frame_err <= abort | extra_clk;
  end
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: directed bench for spi_slave_rx with a frame-level model
// (expected-frame queue, TX buffer and rx_valid state) and a per-cycle monitor.
module tb_spi_slave_rx;
  localparam int W = 8;

  logic         clk = 1'b0, reset = 1'b1;
  logic         sclk = 1'b0, cs = 1'b1, mosi = 1'b0, miso;
  logic [W-1:0] tx_data = '0, rx_data;
  logic         tx_valid = 1'b0, tx_ready;
  logic         rx_valid, rx_ready = 1'b0, rx_overrun, busy;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic         frame_err;
  int           ferr_seen = 0;
`endif

  int errors = 0, checks = 0, ovr_seen = 0;

  // model
  logic [W-1:0] exp_q[$];
  logic         ovr_q[$];
  logic         m_valid = 1'b0, m_tx_full = 1'b0;
  logic [W-1:0] m_tx_buf = '0;
  logic         prev_valid = 1'b0;

  spi_slave_rx #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_overrun(rx_overrun), .busy(busy)
`ifdef SPI_SLAVE_FRAME_ERR_EN
    , .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every posted frame must match the model queue; miso is 0 when idle
  always @(negedge clk) begin
    if (!reset) begin
      if ((rx_valid && !prev_valid) || rx_overrun) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got rx_data %0h with no frame pending", rx_data);
        end else begin
          chk("rx_data", rx_data, exp_q.pop_front());
          chk("rx_overrun", rx_overrun, ovr_q.pop_front());
        end
      end
      if (rx_overrun) ovr_seen++;
      if (!busy) chk("miso_idle", miso, 1'b0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
      if (frame_err) ferr_seen++;
`endif
    end
    prev_valid = rx_valid;
  end

  task automatic preload(input logic [W-1:0] w);
    @(negedge clk); tx_data = w; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
    m_tx_full = 1'b1; m_tx_buf = w;
    chk("tx_ready_full", tx_ready, !m_tx_full);
  endtask

  // mode-0 master, sclk = 8 clk periods; samples miso just before each rise
  task automatic xfer(input logic [W-1:0] d, input int nbits, output logic [W-1:0] got);
    got = '0;
    @(negedge clk); mosi = d[W-1]; cs = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_in_frame", busy, 1'b1);
    for (int i = 0; i < nbits; i++) begin
      got[W-1-i] = miso;
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
      if (i < W-1) mosi = d[W-2-i];
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic frame(input logic [W-1:0] d, output logic [W-1:0] miso_bits);
    logic [W-1:0] exp_miso;
    exp_miso  = m_tx_full ? m_tx_buf : '0;
    m_tx_full = 1'b0;
    exp_q.push_back(d);
    ovr_q.push_back(m_valid);
    m_valid = 1'b1;
    xfer(d, W, miso_bits);
    cs = 1'b1;
    repeat (8) @(negedge clk);
    chk("miso_bits", miso_bits, exp_miso);
    chk("busy_after", busy, 1'b0);
    chk("tx_ready_after", tx_ready, !m_tx_full);
    chk("rx_valid_held", rx_valid, m_valid);
  endtask

  task automatic accept();
    @(negedge clk); rx_ready = 1'b1;
    @(negedge clk); rx_ready = 1'b0; m_valid = 1'b0;
    @(negedge clk);
    chk("rx_valid_cleared", rx_valid, m_valid);
  endtask

  initial begin
    logic [W-1:0] mb;
    // 1: reset values
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_miso", miso, 1'b0);
    chk("rst_tx_ready", tx_ready, 1'b1);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_overrun", rx_overrun, 1'b0);

    // 2: preload 3C, receive A5
    preload(8'h3C);
    frame(8'hA5, mb);
    chk("t2_miso_lit", mb, 8'h3C);
    chk("t2_rx_data_lit", rx_data, 8'hA5);
    chk("t2_tx_ready_lit", tx_ready, 1'b1);
    accept();

    // 3: no preload, receive FF
    frame(8'hFF, mb);
    chk("t3_miso_lit", mb, 8'h00);
    chk("t3_rx_data_lit", rx_data, 8'hFF);
    accept();

    // 4: two frames without consuming
    frame(8'h11, mb);
    frame(8'h22, mb);
    chk("t4_rx_data_lit", rx_data, 8'h22);
    chk("t4_rx_valid_lit", rx_valid, 1'b1);
    chk("t4_overrun_count", ovr_seen, 1);
    accept();

    // 5: abort after 4 bits, then a clean frame
    xfer(8'hF0, 4, mb);
    cs = 1'b1;
    repeat (8) @(negedge clk);
    chk("t5_busy_drop", busy, 1'b0);
    chk("t5_rx_valid", rx_valid, 1'b0);
    chk("t5_rx_data_kept", rx_data, 8'h22);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    chk("t5_frame_err_count", ferr_seen, 1);
`endif
    frame(8'h0F, mb);
    chk("t5_rx_data_lit", rx_data, 8'h0F);
    accept();

    // 6: reset mid-frame (with a pending TX word), then a clean frame
    xfer(8'hC3, 3, mb);
    preload(8'h99);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    m_valid = 1'b0; m_tx_full = 1'b0;
    @(negedge clk); reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_rx_data_rst", rx_data, 8'h00);
    chk("t6_rx_valid_rst", rx_valid, 1'b0);
    chk("t6_tx_ready_rst", tx_ready, 1'b1);
    chk("t6_busy_rst", busy, 1'b0);
    frame(8'h5A, mb);
    chk("t6_rx_data_lit", rx_data, 8'h5A);
    chk("t6_miso_lit", mb, 8'h00);
    accept();

    chk("pending_frames", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
